// File: rtl/decimator_pkg.sv
// Shared types and width helpers for the multichannel decimator.
// Output slot state encoding and derived-width functions live here.
package decimator_pkg;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   function automatic int unsigned dec_ch_width(input int unsigned n_channels);
      return (n_channels > 1) ? 32'($clog2(n_channels)) : 32'd1;
   endfunction

   function automatic int unsigned dec_cnt_width(input int unsigned decimation);
      return 32'($clog2(decimation));
   endfunction

endpackage

// File: rtl/decimator_acc_bank.sv
// Per-channel accumulator and beat counter storage for the decimator.
// Reports completion and the completed sum combinationally for the addressed channel.
module decimator_acc_bank
   import decimator_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned N_CHANNELS = 4,
   parameter int unsigned DECIMATION = 8,
   localparam int unsigned CH_WIDTH  = dec_ch_width(N_CHANNELS),
   localparam int unsigned CNT_WIDTH = dec_cnt_width(DECIMATION),
   localparam int unsigned ACC_WIDTH = DATA_WIDTH + CNT_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         beat_valid,
   input  logic [CH_WIDTH-1:0]          beat_dest,
   input  logic signed [DATA_WIDTH-1:0] beat_data,
   output logic                         done_c,
   output logic signed [ACC_WIDTH-1:0]  sum_c
);

   logic signed [ACC_WIDTH-1:0] acc [N_CHANNELS];
   logic [CNT_WIDTH-1:0]        cnt [N_CHANNELS];
   logic signed [ACC_WIDTH-1:0] acc_sel;
   logic [CNT_WIDTH-1:0]        cnt_sel;
   logic [ACC_WIDTH-1:0]        data_ext;

   // Read mux for the addressed channel
   always_comb begin
      acc_sel = '0;
      cnt_sel = '0;
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
         if (beat_dest == CH_WIDTH'(i)) begin
            acc_sel = acc[i];
            cnt_sel = cnt[i];
         end
      end
   end

   assign data_ext = {{CNT_WIDTH{beat_data[DATA_WIDTH-1]}}, beat_data};
   assign sum_c    = acc_sel + data_ext;
   assign done_c   = beat_valid && (cnt_sel == CNT_WIDTH'(DECIMATION - 1));

   // A completing beat restarts its channel from zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            acc[i] <= '0;
            cnt[i] <= '0;
         end
      end else if (clear) begin
         for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            acc[i] <= '0;
            cnt[i] <= '0;
         end
      end else if (beat_valid) begin
         for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            if (beat_dest == CH_WIDTH'(i)) begin
               if (done_c) begin
                  acc[i] <= '0;
                  cnt[i] <= '0;
               end else begin
                  acc[i] <= sum_c;
                  cnt[i] <= cnt[i] + CNT_WIDTH'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/multichannel_decimator.sv
// Multichannel decimating accumulator: sums DECIMATION samples per channel, emits mean or sum.
// Optional macro DECIMATOR_ROUNDING_EN makes the mean round half up instead of flooring.
module multichannel_decimator
   import decimator_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned N_CHANNELS = 4,
   parameter int unsigned DECIMATION = 8,
   parameter int unsigned AVERAGE    = 1,
   localparam int unsigned CH_WIDTH  = dec_ch_width(N_CHANNELS),
   localparam int unsigned CNT_WIDTH = dec_cnt_width(DECIMATION),
   localparam int unsigned ACC_WIDTH = DATA_WIDTH + CNT_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic [CH_WIDTH-1:0]          in_dest,
   input  logic                         clear,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_WIDTH-1:0]  out_data,
   output logic [CH_WIDTH-1:0]          out_dest,
   output logic                         dest_error
);

   slot_state_e                 state;
   slot_state_e                 state_d;
   logic                        accept_c;
   logic                        in_range_c;
   logic                        beat_valid_c;
   logic                        done_c;
   logic                        load_c;
   logic signed [ACC_WIDTH-1:0] sum_c;
   logic signed [ACC_WIDTH-1:0] result_c;

   assign in_ready     = !out_valid || out_ready;
   assign accept_c     = in_valid && in_ready;
   assign in_range_c   = 32'(in_dest) < N_CHANNELS;
   assign beat_valid_c = accept_c && in_range_c && !clear;

   decimator_acc_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .N_CHANNELS (N_CHANNELS),
      .DECIMATION (DECIMATION)
   ) u_acc_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .beat_valid (beat_valid_c),
      .beat_dest  (in_dest),
      .beat_data  (in_data),
      .done_c     (done_c),
      .sum_c      (sum_c)
   );

   // Result scaling; the sum has headroom for the rounding bias
   generate
      if (AVERAGE != 0) begin : g_avg
`ifdef DECIMATOR_ROUNDING_EN
         localparam logic [ACC_WIDTH-1:0] HALF_LSB = ACC_WIDTH'(DECIMATION / 2);
         logic signed [ACC_WIDTH-1:0] biased_c;
         assign biased_c = sum_c + HALF_LSB;
         assign result_c = biased_c >>> CNT_WIDTH;
`else
         assign result_c = sum_c >>> CNT_WIDTH;
`endif
      end else begin : g_sum
         assign result_c = sum_c;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SLOT_EMPTY;
      end else begin
         state <= state_d;
      end
   end

   // Output slot: a completion always loads; drain only when no new result arrives
   always_comb begin
      state_d = state;
      load_c  = 1'b0;
      case (state)
         SLOT_EMPTY: begin
            if (done_c) begin
               state_d = SLOT_FULL;
               load_c  = 1'b1;
            end
         end
         SLOT_FULL: begin
            if (done_c) begin
               state_d = SLOT_FULL;
               load_c  = 1'b1;
            end else if (out_ready) begin
               state_d = SLOT_EMPTY;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   assign out_valid = (state == SLOT_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_dest <= '0;
      end else if (load_c) begin
         out_data <= result_c;
         out_dest <= in_dest;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dest_error <= 1'b0;
      end else if (accept_c && !in_range_c) begin
         dest_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multichannel_decimator.sv
// Bench for multichannel_decimator: mean instance (4 channels) and sum instance (5 channels).
// Per-channel sample queues model the expected results; honours DECIMATOR_ROUNDING_EN.
module tb_multichannel_decimator;

   localparam int NA  = 4;
   localparam int NB  = 5;
   localparam int DEC = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic               a_in_valid, a_in_ready, a_clear, a_out_valid, a_out_ready, a_dest_error;
   logic signed [15:0] a_in_data;
   logic [1:0]         a_in_dest, a_out_dest;
   logic signed [18:0] a_out_data;

   logic               b_in_valid, b_in_ready, b_clear, b_out_valid, b_out_ready, b_dest_error;
   logic signed [15:0] b_in_data;
   logic [2:0]         b_in_dest, b_out_dest;
   logic signed [18:0] b_out_data;

   multichannel_decimator #(
      .DATA_WIDTH (16), .N_CHANNELS (NA), .DECIMATION (DEC), .AVERAGE (1)
   ) dut_a (
      .clk (clk), .rst_n (rst_n), .in_valid (a_in_valid), .in_ready (a_in_ready),
      .in_data (a_in_data), .in_dest (a_in_dest), .clear (a_clear),
      .out_valid (a_out_valid), .out_ready (a_out_ready), .out_data (a_out_data),
      .out_dest (a_out_dest), .dest_error (a_dest_error)
   );

   multichannel_decimator #(
      .DATA_WIDTH (16), .N_CHANNELS (NB), .DECIMATION (DEC), .AVERAGE (0)
   ) dut_b (
      .clk (clk), .rst_n (rst_n), .in_valid (b_in_valid), .in_ready (b_in_ready),
      .in_data (b_in_data), .in_dest (b_in_dest), .clear (b_clear),
      .out_valid (b_out_valid), .out_ready (b_out_ready), .out_data (b_out_data),
      .out_dest (b_out_dest), .dest_error (b_dest_error)
   );

   int     checks = 0;
   int     errors = 0;
   int     chq   [2][8][$];
   longint exp_d [2][$];
   int     exp_dst [2][$];
   bit     exp_err [2];
   bit     dv [2], dordy [2], dclr [2];
   int     ddst [2], ddat [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic longint floor_div(input longint n, input longint d);
      if (n >= 0) return n / d;
      return -((-n + d - 1) / d);
   endfunction

   task automatic apply();
      a_in_valid = dv[0]; a_in_dest = 2'(ddst[0]); a_in_data = 16'(ddat[0]);
      a_out_ready = dordy[0]; a_clear = dclr[0];
      b_in_valid = dv[1]; b_in_dest = 3'(ddst[1]); b_in_data = 16'(ddat[1]);
      b_out_ready = dordy[1]; b_clear = dclr[1];
   endtask

   task automatic idle_all();
      for (int k = 0; k < 2; k++) begin
         dv[k] = 1'b0; ddst[k] = 0; ddat[k] = 0; dordy[k] = 1'b1; dclr[k] = 1'b0;
      end
   endtask

   task automatic check_and_model(input int k);
      logic        ov, ir, oe;
      logic [18:0] od, e19;
      int          odst, nch;
      bit          ev, acc_ok;
      longint      s;
      nch = (k == 0) ? NA : NB;
      if (k == 0) begin
         ov = a_out_valid; ir = a_in_ready; oe = a_dest_error; od = a_out_data; odst = int'(a_out_dest);
      end else begin
         ov = b_out_valid; ir = b_in_ready; oe = b_dest_error; od = b_out_data; odst = int'(b_out_dest);
      end
      ev = exp_d[k].size() != 0;
      chk($sformatf("out_valid[%0d]", k), 32'(ov), 32'(ev));
      chk($sformatf("in_ready[%0d]", k), 32'(ir), 32'(!ev || dordy[k]));
      chk($sformatf("dest_error[%0d]", k), 32'(oe), 32'(exp_err[k]));
      if (ev) begin
         e19 = 19'(exp_d[k][0]);
         chk($sformatf("out_data[%0d]", k), 32'(od), 32'(e19));
         chk($sformatf("out_dest[%0d]", k), 32'(odst), 32'(exp_dst[k][0]));
      end
      // Behaviour across the coming clock edge
      acc_ok = dv[k] && (!ev || dordy[k]);
      if (ev && dordy[k]) begin
         void'(exp_d[k].pop_front());
         void'(exp_dst[k].pop_front());
      end
      if (acc_ok && ddst[k] >= nch) exp_err[k] = 1'b1;
      if (dclr[k]) begin
         for (int c = 0; c < 8; c++) chq[k][c].delete();
      end else if (acc_ok && ddst[k] < nch) begin
         chq[k][ddst[k]].push_back(ddat[k]);
         if (chq[k][ddst[k]].size() == DEC) begin
            s = 0;
            for (int j = 0; j < DEC; j++) s += longint'(chq[k][ddst[k]][j]);
            if (k == 0) begin
`ifdef DECIMATOR_ROUNDING_EN
               s = floor_div(s + DEC / 2, DEC);
`else
               s = floor_div(s, DEC);
`endif
            end
            exp_d[k].push_back(s);
            exp_dst[k].push_back(ddst[k]);
            chq[k][ddst[k]].delete();
         end
      end
   endtask

   task automatic step(input int w, input bit v, input int dst, input int dat, input bit ordy, input bit clr);
      idle_all();
      dv[w] = v; ddst[w] = dst; ddat[w] = dat; dordy[w] = ordy; dclr[w] = clr;
      apply();
      #1;
      for (int k = 0; k < 2; k++) check_and_model(k);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_all();
      apply();
      rst_n = 1'b0;
      #2;
      chk("rst a_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst a_out_data", 32'(a_out_data), 32'd0);
      chk("rst a_out_dest", 32'(a_out_dest), 32'd0);
      chk("rst a_dest_error", 32'(a_dest_error), 32'd0);
      chk("rst b_out_valid", 32'(b_out_valid), 32'd0);
      chk("rst b_dest_error", 32'(b_dest_error), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 8; c++) chq[k][c].delete();
         exp_d[k].delete();
         exp_dst[k].delete();
         exp_err[k] = 1'b0;
      end
   endtask

   task automatic drain(input int w, input int n);
      for (int i = 0; i < n; i++) step(w, 1'b0, 0, 0, 1'b1, 1'b0);
   endtask

   function automatic int rnd16();
      logic signed [15:0] r;
      r = 16'($urandom);
      return int'(r);
   endfunction

   initial begin
      rst_n = 1'b0;
      do_reset();

      // Mean of 8 x 100 on channel 2, one cycle after the last beat
      for (int i = 0; i < 8; i++) step(0, 1'b1, 2, 100, 1'b1, 1'b0);
      chk("avg100 valid", 32'(a_out_valid), 32'd1);
      chk("avg100 data", 32'(a_out_data), 32'd100);
      chk("avg100 dest", 32'(a_out_dest), 32'd2);
      drain(0, 2);

      // Interleaved channels 0/1 with 1..16
      for (int i = 1; i <= 16; i++) step(0, 1'b1, (i - 1) % 2, i, 1'b1, 1'b0);
      drain(0, 2);

      // Backpressure: pending result stalls input and holds data
      for (int i = 0; i < 8; i++) step(0, 1'b1, 3, rnd16(), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(0, 1'b1, 0, 555, 1'b0, 1'b0);
      chk("stall in_ready", 32'(a_in_ready), 32'(!a_out_valid));
      drain(0, 2);

      // Rounding sensitivity: 1,1,1,1,2,2,2,2
      for (int i = 0; i < 8; i++) step(0, 1'b1, 1, (i < 4) ? 1 : 2, 1'b1, 1'b0);
`ifdef DECIMATOR_ROUNDING_EN
      chk("round avg", 32'(a_out_data), 32'd2);
`else
      chk("floor avg", 32'(a_out_data), 32'd1);
`endif
      drain(0, 2);

      // Clear discards partial sums and the coincident beat
      for (int i = 0; i < 3; i++) step(0, 1'b1, 1, 50, 1'b1, 1'b0);
      step(0, 1'b1, 1, 999, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(0, 1'b1, 1, 7, 1'b1, 1'b0);
      chk("clear avg", 32'(a_out_data), 32'd7);
      drain(0, 2);

      // Randomised traffic with backpressure and occasional clear
      for (int i = 0; i < 400; i++)
         step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3), rnd16(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      drain(0, 3);

      // Reset mid-accumulation drops the partial sum
      for (int i = 0; i < 4; i++) step(0, 1'b1, 0, 1000, 1'b1, 1'b0);
      do_reset();
      for (int i = 0; i < 8; i++) step(0, 1'b1, 0, 10, 1'b1, 1'b0);
      chk("post-reset avg", 32'(a_out_data), 32'd10);
      drain(0, 3);

      // Full-sum instance: negative full scale
      for (int i = 0; i < 8; i++) step(1, 1'b1, 0, -32768, 1'b1, 1'b0);
      chk("negfs valid", 32'(b_out_valid), 32'd1);
      chk("negfs data", 32'(b_out_data), 32'(-262144));
      drain(1, 2);

      // Out-of-range destination is dropped and flagged
      step(1, 1'b1, 5, 1234, 1'b1, 1'b0);
      chk("dest_error set", 32'(b_dest_error), 32'd1);
      for (int i = 0; i < 8; i++) step(1, 1'b1, 0, rnd16(), 1'b1, 1'b0);
      drain(1, 2);

      for (int i = 0; i < 300; i++)
         step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 7), rnd16(),
              $urandom_range(0, 3) != 0, 1'b0);
      drain(1, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multichannel_decimator.md
MULTICHANNEL_DECIMATOR -- requirements
Module: multichannel_decimator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed input sample width.
REQ-002 SHALL have parameter N_CHANNELS, default 4, number of independent channels (>=1).
REQ-003 SHALL have parameter DECIMATION, default 8, samples per output; power of two, >=2.
REQ-004 SHALL have parameter AVERAGE, default 1, 1 = output mean, 0 = output full sum.
REQ-005 SHALL derive localparams CH_WIDTH = max(1, $clog2(N_CHANNELS)), CNT_WIDTH = $clog2(DECIMATION), ACC_WIDTH = DATA_WIDTH + CNT_WIDTH.
REQ-006 SHALL have clock, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have in_valid/in_ready, input/output, 1 each, input handshake.
REQ-009 SHALL have in_data, input, DATA_WIDTH, signed sample; in_dest, input, CH_WIDTH, channel index.
REQ-010 SHALL have clear, input, 1, synchronous flush of all partial accumulations.
REQ-011 SHALL have out_valid/out_ready, output/input, 1 each, output handshake.
REQ-012 SHALL have out_data, output, ACC_WIDTH, signed result; out_dest, output, CH_WIDTH, result channel.
REQ-013 SHALL have dest_error, output, 1, sticky flag for out-of-range in_dest.

Function
REQ-014 SHALL accept a beat when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-015 SHALL, on accepted beat with in_dest >= N_CHANNELS, drop it, leave all channel state unchanged, set dest_error.
REQ-016 SHALL, on accepted valid beat, add sign-extended in_data to acc[in_dest] and increment cnt[in_dest].
REQ-017 SHALL, when the beat brings cnt to DECIMATION, form result = acc + in_data, zero acc and cnt of that channel, load output register.
REQ-018 SHALL present result with out_valid high on the cycle after the completing beat (latency 1).
REQ-019 SHALL, AVERAGE=1, output result arithmetically shifted right by CNT_WIDTH, sign-extended to ACC_WIDTH; AVERAGE=0, output result unmodified.
REQ-020 SHALL never overflow: ACC_WIDTH holds DECIMATION full-scale samples of either sign.
REQ-021 SHALL implement output slot FSM EMPTY/FULL: EMPTY->FULL on completion; FULL->EMPTY on out_ready without completion; FULL->FULL with new data on simultaneous out_ready and completion.
REQ-022 SHALL hold out_data/out_dest stable while out_valid && !out_ready.
REQ-023 SHALL, on clear, zero all acc/cnt; a beat accepted in the same cycle is discarded; output slot and dest_error untouched.
REQ-024 SHALL clear dest_error only on reset.

Reset
REQ-025 SHALL on reset low drive out_valid=0, out_data=0, out_dest=0, dest_error=0, zero all acc/cnt, FSM=EMPTY, regardless of clock.
REQ-026 SHALL discard partial sums on reset mid-operation; no output produced from pre-reset samples.

Configuration
REQ-027 SHALL support macro DECIMATOR_ROUNDING_EN: defined, AVERAGE=1 adds 2^(CNT_WIDTH-1) before shift (round half up); undefined, plain truncating shift (floor); AVERAGE=0 unaffected.

Structure
REQ-028 SHALL place output FSM state enum and DECIMATOR width helper constants in package decimator_pkg.
REQ-029 SHALL implement per-channel acc/cnt storage and update as sub-module decimator_acc_bank.

Verification (DATA_WIDTH=16, N_CHANNELS=4, DECIMATION=8)
REQ-030 SHALL test: 8 beats of 100 on dest 2, AVERAGE=1 -> one output 100, dest 2, one cycle after 8th beat.
REQ-031 SHALL test: AVERAGE=0, 8 beats of -32768 on dest 0 -> out_data = -262144 (19 bit).
REQ-032 SHALL test: alternating dest 0/1 with values 1..16 -> dest 0 avg 8 (sum 64), dest 1 avg 9 (sum 72).
REQ-033 SHALL test: out_ready held low with output pending -> in_ready low, out_data stable; out_ready high -> transfer, in_ready high.
REQ-034 SHALL test: in_dest=5 -> beat dropped, dest_error=1, later 8 beats on dest 0 still produce correct output.
REQ-035 SHALL test: values 1,1,1,1,2,2,2,2 -> avg 1 without DECIMATOR_ROUNDING_EN, 2 with; 4 beats then reset then 8 beats of 10 -> single output 10.
